// File: rtl/ps2_voice_allocator_if.sv
// rtl/ps2_voice_allocator_if.sv - PS/2 byte input and note event output bundle
interface ps2_voice_allocator_if;
  logic [7:0] ps2_data;
  logic       ps2_data_en;
  logic       evt_valid;
  logic       evt_ready;
  logic       evt_on;
  logic [1:0] evt_voice;
  logic [4:0] evt_note;

  modport master (
    output ps2_data, ps2_data_en, evt_ready,
    input  evt_valid, evt_on, evt_voice, evt_note
  );

  modport slave (
    input  ps2_data, ps2_data_en, evt_ready,
    output evt_valid, evt_on, evt_voice, evt_note
  );
endinterface

// File: rtl/ps2_voice_allocator.sv
// rtl/ps2_voice_allocator.sv - PS/2 scan-code parser, 4-voice note allocator and event FIFO
module ps2_voice_allocator #(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  ps2_voice_allocator_if.slave  bus,
  output logic [3:0]            voice_active,
  output logic [19:0]           voice_note,
  output logic                  dropped,
  output logic                  overflow
);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  state_t        state, state_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          strobe, timed_out;

  logic [4:0]    note_r [4];
  logic          key_ok;
  logic [4:0]    key_idx;
  logic          do_press, do_release;
  logic          held_hit, free_found;
  logic [1:0]    held_voice, free_voice;
  logic          claim, free_held, drop_now;
  logic          push_en;
  logic [7:0]    push_data;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          fifo_empty, fifo_full, pop, wr_ok;

  // {mapped, note index}; unmapped codes (including F0/E0) return 0
  function automatic logic [5:0] key_map(input logic [7:0] c);
    case (c)
      8'h1C: key_map = {1'b1, 5'd0};
      8'h1D: key_map = {1'b1, 5'd1};
      8'h1B: key_map = {1'b1, 5'd2};
      8'h24: key_map = {1'b1, 5'd3};
      8'h23: key_map = {1'b1, 5'd4};
      8'h2B: key_map = {1'b1, 5'd5};
      8'h2C: key_map = {1'b1, 5'd6};
      8'h34: key_map = {1'b1, 5'd7};
      8'h35: key_map = {1'b1, 5'd8};
      8'h33: key_map = {1'b1, 5'd9};
      8'h3C: key_map = {1'b1, 5'd10};
      8'h3B: key_map = {1'b1, 5'd11};
      8'h42: key_map = {1'b1, 5'd12};
      8'h44: key_map = {1'b1, 5'd13};
      8'h4B: key_map = {1'b1, 5'd14};
      8'h4D: key_map = {1'b1, 5'd15};
      8'h4C: key_map = {1'b1, 5'd16};
      default: key_map = 6'd0;
    endcase
  endfunction

  assign strobe           = bus.ps2_data_en;
  assign {key_ok, key_idx} = key_map(bus.ps2_data);
  assign timed_out        = (state != IDLE) && !strobe && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (strobe || state_nxt == IDLE) tmo_cnt <= '0;
      else                              tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    if (timed_out) begin
      state_nxt = IDLE;
    end else if (strobe) begin
      case (state)
        IDLE:    if (bus.ps2_data == 8'hF0)      state_nxt = BRK;
                 else if (bus.ps2_data == 8'hE0) state_nxt = EXT;
        BRK:     state_nxt = IDLE;
        EXT:     state_nxt = (bus.ps2_data == 8'hF0) ? EXT_BRK : IDLE;
        EXT_BRK: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    do_press   = strobe && (state == IDLE) && key_ok;
    do_release = strobe && (state == BRK) && key_ok;
  end

  // Match against held notes, and pick the lowest free voice by scanning downward
  always_comb begin
    held_hit   = 1'b0;
    held_voice = 2'd0;
    free_found = 1'b0;
    free_voice = 2'd0;
    for (int v = 0; v < 4; v++) begin
      if (voice_active[v] && note_r[v] == key_idx) begin
        held_hit   = 1'b1;
        held_voice = 2'(v);
      end
    end
    for (int v = 3; v >= 0; v--) begin
      if (!voice_active[v]) begin
        free_found = 1'b1;
        free_voice = 2'(v);
      end
    end
  end

  always_comb begin
    claim     = do_press && !held_hit && free_found;
    drop_now  = do_press && !held_hit && !free_found;
    free_held = do_release && held_hit;
    push_en   = claim || free_held;
    push_data = claim ? {1'b1, free_voice, key_idx} : {1'b0, held_voice, key_idx};
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      voice_active <= '0;
      dropped      <= 1'b0;
      for (int v = 0; v < 4; v++) note_r[v] <= '0;
    end else begin
      dropped <= drop_now;
      if (claim) begin
        voice_active[free_voice] <= 1'b1;
        note_r[free_voice]       <= key_idx;
      end
      if (free_held) begin
        voice_active[held_voice] <= 1'b0;
        note_r[held_voice]       <= '0;
      end
    end
  end

  always_comb begin
    for (int v = 0; v < 4; v++) voice_note[5*v +: 5] = note_r[v];
  end

  // Pointers carry an extra wrap bit so full and empty are distinguishable
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !fifo_empty && bus.evt_ready;
  assign wr_ok      = push_en && (!fifo_full || pop);

  always_ff @(posedge CLOCK_50) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok)            wr_ptr   <= wr_ptr + 1'b1;
      if (pop)              rd_ptr   <= rd_ptr + 1'b1;
      if (push_en && !wr_ok) overflow <= 1'b1;
    end
  end

  assign bus.evt_valid = !fifo_empty;
  assign {bus.evt_on, bus.evt_voice, bus.evt_note} = fifo_empty ? 8'd0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// tb/tb_ps2_voice_allocator.sv - directed vector bench for ps2_voice_allocator
module tb_ps2_voice_allocator;
  localparam int T = 20;
  localparam logic [8:0] NO_EV = 9'd0;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [3:0]  voice_active;
  logic [19:0] voice_note;
  logic        dropped, overflow;
  int          n_checks = 0;
  int          n_fail = 0;

  ps2_voice_allocator_if bus_if ();

  ps2_voice_allocator #(.TIMEOUT_CYCLES(T), .FIFO_DEPTH(4)) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .bus          (bus_if),
    .voice_active (voice_active),
    .voice_note   (voice_note),
    .dropped      (dropped),
    .overflow     (overflow)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [7:0]  code;
    logic [3:0]  act;
    logic [19:0] notes;
    logic        drop;
    logic [8:0]  evt;
  } vec_t;

  vec_t vecs [28];

  function automatic logic [8:0] ev(input logic on, input logic [1:0] v, input logic [4:0] n);
    ev = {1'b1, on, v, n};
  endfunction

  function automatic logic [19:0] nt(input logic [4:0] n3, n2, n1, n0);
    nt = {n3, n2, n1, n0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [8:0] evt_bundle();
    evt_bundle = {bus_if.evt_valid, bus_if.evt_on, bus_if.evt_voice, bus_if.evt_note};
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge CLOCK_50);
    bus_if.ps2_data    = b;
    bus_if.ps2_data_en = 1'b1;
    @(negedge CLOCK_50);
    bus_if.ps2_data_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
  endtask

  task automatic pop_check(input string name, input logic [8:0] exp);
    chk(name, 32'(evt_bundle()), 32'(exp));
    bus_if.evt_ready = 1'b1;
    @(negedge CLOCK_50);
    bus_if.evt_ready = 1'b0;
  endtask

  initial begin
    reset              = 1'b1;
    bus_if.ps2_data    = 8'h00;
    bus_if.ps2_data_en = 1'b0;
    bus_if.evt_ready   = 1'b1;

    vecs[0]  = '{8'h1C, 4'b0001, nt(0,0,0,0),  1'b0, ev(1,0,0)};
    vecs[1]  = '{8'hF0, 4'b0001, nt(0,0,0,0),  1'b0, NO_EV};
    vecs[2]  = '{8'h1C, 4'b0000, nt(0,0,0,0),  1'b0, ev(0,0,0)};
    vecs[3]  = '{8'h1C, 4'b0001, nt(0,0,0,0),  1'b0, ev(1,0,0)};
    vecs[4]  = '{8'h1B, 4'b0011, nt(0,0,2,0),  1'b0, ev(1,1,2)};
    vecs[5]  = '{8'h23, 4'b0111, nt(0,4,2,0),  1'b0, ev(1,2,4)};
    vecs[6]  = '{8'h2B, 4'b1111, nt(5,4,2,0),  1'b0, ev(1,3,5)};
    vecs[7]  = '{8'h34, 4'b1111, nt(5,4,2,0),  1'b1, NO_EV};
    vecs[8]  = '{8'h1C, 4'b1111, nt(5,4,2,0),  1'b0, NO_EV};
    vecs[9]  = '{8'hE0, 4'b1111, nt(5,4,2,0),  1'b0, NO_EV};
    vecs[10] = '{8'hF0, 4'b1111, nt(5,4,2,0),  1'b0, NO_EV};
    vecs[11] = '{8'h1C, 4'b1111, nt(5,4,2,0),  1'b0, NO_EV};
    vecs[12] = '{8'hF0, 4'b1111, nt(5,4,2,0),  1'b0, NO_EV};
    vecs[13] = '{8'h1B, 4'b1101, nt(5,4,0,0),  1'b0, ev(0,1,2)};
    vecs[14] = '{8'h34, 4'b1111, nt(5,4,7,0),  1'b0, ev(1,1,7)};
    vecs[15] = '{8'h12, 4'b1111, nt(5,4,7,0),  1'b0, NO_EV};
    vecs[16] = '{8'hF0, 4'b1111, nt(5,4,7,0),  1'b0, NO_EV};
    vecs[17] = '{8'h12, 4'b1111, nt(5,4,7,0),  1'b0, NO_EV};
    vecs[18] = '{8'hF0, 4'b1111, nt(5,4,7,0),  1'b0, NO_EV};
    vecs[19] = '{8'hF0, 4'b1111, nt(5,4,7,0),  1'b0, NO_EV};
    vecs[20] = '{8'h1C, 4'b1111, nt(5,4,7,0),  1'b0, NO_EV};
    vecs[21] = '{8'hE0, 4'b1111, nt(5,4,7,0),  1'b0, NO_EV};
    vecs[22] = '{8'h1C, 4'b1111, nt(5,4,7,0),  1'b0, NO_EV};
    vecs[23] = '{8'hF0, 4'b1111, nt(5,4,7,0),  1'b0, NO_EV};
    vecs[24] = '{8'h1C, 4'b1110, nt(5,4,7,0),  1'b0, ev(0,0,0)};
    vecs[25] = '{8'h4C, 4'b1111, nt(5,4,7,16), 1'b0, ev(1,0,16)};
    vecs[26] = '{8'hF0, 4'b1111, nt(5,4,7,16), 1'b0, NO_EV};
    vecs[27] = '{8'h4C, 4'b1110, nt(5,4,7,0),  1'b0, ev(0,0,16)};

    do_reset();
    chk("rst_active",   32'(voice_active), 32'd0);
    chk("rst_notes",    32'(voice_note),   32'd0);
    chk("rst_evt",      32'(evt_bundle()), 32'd0);
    chk("rst_dropped",  32'(dropped),      32'd0);
    chk("rst_overflow", 32'(overflow),     32'd0);

    for (int i = 0; i < 28; i++) begin
      send(vecs[i].code);
      chk($sformatf("vec%0d_active", i), 32'(voice_active), 32'(vecs[i].act));
      chk($sformatf("vec%0d_notes", i),  32'(voice_note),   32'(vecs[i].notes));
      chk($sformatf("vec%0d_dropped", i), 32'(dropped),     32'(vecs[i].drop));
      chk($sformatf("vec%0d_evt", i),    32'(evt_bundle()), 32'(vecs[i].evt));
    end
    @(negedge CLOCK_50);
    chk("dropped_one_cycle", 32'(dropped), 32'd0);

    // Prefix abandoned after the timeout: 1C becomes a press
    do_reset();
    send(8'hF0);
    repeat (T + 2) @(negedge CLOCK_50);
    send(8'h1C);
    chk("timeout_evt",    32'(evt_bundle()),  32'(ev(1,0,0)));
    chk("timeout_active", 32'(voice_active),  32'b0001);

    // Prefix still live before the timeout: 1C is a release
    send(8'hF0);
    repeat (T - 5) @(negedge CLOCK_50);
    send(8'h1C);
    chk("pre_timeout_evt",    32'(evt_bundle()), 32'(ev(0,0,0)));
    chk("pre_timeout_active", 32'(voice_active), 32'b0000);

    // Reset after F0, with a strobe during reset, discards the prefix
    send(8'h1C);
    send(8'hF0);
    @(negedge CLOCK_50);
    reset              = 1'b1;
    bus_if.ps2_data    = 8'h1C;
    bus_if.ps2_data_en = 1'b1;
    @(negedge CLOCK_50);
    bus_if.ps2_data_en = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b0;
    chk("midrst_active", 32'(voice_active), 32'd0);
    chk("midrst_evt",    32'(evt_bundle()), 32'd0);
    send(8'h1C);
    chk("midrst_press_evt",    32'(evt_bundle()), 32'(ev(1,0,0)));
    chk("midrst_press_active", 32'(voice_active), 32'b0001);

    // Overflow with consumer stalled
    do_reset();
    bus_if.evt_ready = 1'b0;
    send(8'h1C);
    send(8'h1B);
    send(8'hF0);
    send(8'h1C);
    send(8'h23);
    chk("full_no_overflow", 32'(overflow),     32'd0);
    chk("full_head",        32'(evt_bundle()), 32'(ev(1,0,0)));
    send(8'h2B);
    chk("overflow_set", 32'(overflow), 32'd1);
    send(8'hF0);
    send(8'h1B);
    chk("ovf_active", 32'(voice_active), 32'b0101);
    chk("ovf_notes",  32'(voice_note),   32'(nt(0,5,0,4)));

    // Push and pop on the same edge while full
    @(negedge CLOCK_50);
    bus_if.evt_ready   = 1'b1;
    bus_if.ps2_data    = 8'h1B;
    bus_if.ps2_data_en = 1'b1;
    @(negedge CLOCK_50);
    bus_if.evt_ready   = 1'b0;
    bus_if.ps2_data_en = 1'b0;
    chk("pushpop_overflow_sticky", 32'(overflow),     32'd1);
    chk("pushpop_active",          32'(voice_active), 32'b0111);
    chk("pushpop_notes",           32'(voice_note),   32'(nt(0,5,2,4)));
    pop_check("pop0", ev(1,1,2));
    pop_check("pop1", ev(0,0,0));
    pop_check("pop2", ev(1,0,4));
    pop_check("pop3", ev(1,1,2));
    chk("drained_evt", 32'(evt_bundle()), 32'd0);

    do_reset();
    chk("final_rst_overflow", 32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
